wrb_port_arbiter: RTL

//  Shares the single register-file write port between the in-order writeback stream (LSU/ALU/CSR)
//  and the out-of-order divider result. A one-entry hold register parks the divider result until
//  a free writeback slot appears. A wait counter bounds starvation by stalling the pipeline for one cycle.

---
 rtl/wrb_port_arbiter_pkg.sv | 45 ++++
 rtl/wrb_arb_perf.sv | 44 ++++
 rtl/wrb_port_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/wrb_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wrb_port_arbiter_pkg
//   Shared types and helpers for the writeback port arbiter.
//   - XLEN           : data width taken from the shared `XLEN define
//   - state encoding : IDLE / PEND / FORCE (enum plus legacy localparams)
//   - type_div2arb_s : divider result bundle {valid, rd_addr, result}
//   - type_arb2rf_s  : register-file write bundle {wr_en, wr_addr, wr_data}
//   - pipe_slot_free : a writeback slot can be reused when nothing (or x0)
//                      is being written
// -----------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif

package wrb_port_arbiter_pkg;

    localparam int XLEN = `XLEN;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FORCE = 2'd2
    } type_wrb_arb_state_e;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PEND  = 2'd1;
    localparam logic [1:0] ST_FORCE = 2'd2;

    typedef struct packed {
        logic            valid;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] result;
    } type_div2arb_s;

    typedef struct packed {
        logic            wr_en;
        logic [4:0]      wr_addr;
        logic [XLEN-1:0] wr_data;
    } type_arb2rf_s;

    function automatic logic pipe_slot_free(input logic req, input logic [4:0] addr);
        return (!req) || (addr == 5'd0);
    endfunction

endpackage

// File: rtl/wrb_arb_perf.sv
// -----------------------------------------------------------------------------
// wrb_arb_perf
//   Saturating event counters for the writeback port arbiter. Only
//   instantiated when WRB_ARB_PERF_EN is defined.
//   Ports:
//     clk, rst              clock / async active-high reset
//     force_i               one pulse per FORCE cycle
//     waw_kill_i            one pulse per held result dropped by a WAW write
//     force_cnt_o           saturating count of force_i
//     waw_kill_cnt_o        saturating count of waw_kill_i
// -----------------------------------------------------------------------------
module wrb_arb_perf #(
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              force_i,
    input  logic              waw_kill_i,
    output logic [PERF_W-1:0] force_cnt_o,
    output logic [PERF_W-1:0] waw_kill_cnt_o
);

    logic [PERF_W-1:0] force_cnt_q;
    logic [PERF_W-1:0] waw_kill_cnt_q;

    // Saturating counters: stick at all-ones instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            force_cnt_q    <= '0;
            waw_kill_cnt_q <= '0;
        end else begin
            if (force_i && (force_cnt_q != {PERF_W{1'b1}})) begin
                force_cnt_q <= force_cnt_q + {{(PERF_W-1){1'b0}}, 1'b1};
            end
            if (waw_kill_i && (waw_kill_cnt_q != {PERF_W{1'b1}})) begin
                waw_kill_cnt_q <= waw_kill_cnt_q + {{(PERF_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign force_cnt_o    = force_cnt_q;
    assign waw_kill_cnt_o = waw_kill_cnt_q;

endmodule

// File: rtl/wrb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wrb_port_arbiter
//   Shares the single register-file write port between the in-order writeback
//   stream and the out-of-order divider. A one-entry hold register parks a
//   divider result until a writeback slot is free; a wait counter bounds
//   starvation by stealing one slot (stalling the pipe for one cycle).
//   Optional feature macro: WRB_ARB_PERF_EN (adds saturating perf counters).
//   Ports:
//     clk, rst                          clock / async active-high reset
//     pipe_wr_req_i/rd_addr_i/rd_data_i writeback stream write request
//     div_valid_i/rd_addr_i/result_i    divider result (held until accepted)
//     div_ready_o                       divider result accepted this cycle
//     pipe_stall_o                      slot stolen, pipe holds its wrb stage
//     pend_valid_o, pend_rd_addr_o      hold register occupancy and rd
//     rf_wr_en_o/addr_o/data_o          register-file write port
//     perf_force_cnt_o                  (WRB_ARB_PERF_EN) FORCE cycles
//     perf_waw_kill_cnt_o               (WRB_ARB_PERF_EN) WAW-dropped results
// -----------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif

module wrb_port_arbiter
    import wrb_port_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int PERF_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_wr_req_i,
    input  logic [4:0]        pipe_rd_addr_i,
    input  logic [XLEN-1:0]   pipe_rd_data_i,
    input  logic              div_valid_i,
    input  logic [4:0]        div_rd_addr_i,
    input  logic [XLEN-1:0]   div_result_i,
    output logic              div_ready_o,
    output logic              pipe_stall_o,
    output logic              pend_valid_o,
    output logic [4:0]        pend_rd_addr_o,
    output logic              rf_wr_en_o,
    output logic [4:0]        rf_wr_addr_o,
    output logic [XLEN-1:0]   rf_wr_data_o
`ifdef WRB_ARB_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_force_cnt_o,
    output logic [PERF_W-1:0] perf_waw_kill_cnt_o
`endif
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic [1:0]       state_q,     state_d;
    logic [4:0]       hold_addr_q, hold_addr_d;
    logic [XLEN-1:0]  hold_data_q, hold_data_d;
    logic [CNT_W-1:0] wait_cnt_q,  wait_cnt_d;

    type_div2arb_s    div_s;
    type_arb2rf_s     rf_s;
    logic             waw_kill_s;

    assign div_s = '{valid: div_valid_i, rd_addr: div_rd_addr_i, result: div_result_i};

    // Next-state and write-port selection
    always_comb begin
        state_d     = state_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        wait_cnt_d  = wait_cnt_q;
        waw_kill_s  = 1'b0;
        // x0 is architecturally zero, so a pipe write to it is masked
        rf_s = '{wr_en:   pipe_wr_req_i && (pipe_rd_addr_i != 5'd0),
                 wr_addr: pipe_rd_addr_i,
                 wr_data: pipe_rd_data_i};
        case (state_q)
            ST_IDLE: begin
                // A result for x0 is accepted and silently discarded
                if (div_s.valid && (div_s.rd_addr != 5'd0)) begin
                    hold_addr_d = div_s.rd_addr;
                    hold_data_d = div_s.result;
                    wait_cnt_d  = '0;
                    state_d     = ST_PEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PEND: begin
                if (pipe_slot_free(pipe_wr_req_i, pipe_rd_addr_i)) begin
                    rf_s    = '{wr_en: 1'b1, wr_addr: hold_addr_q, wr_data: hold_data_q};
                    state_d = ST_IDLE;
                end else if (pipe_rd_addr_i == hold_addr_q) begin
                    // Younger pipe write to the same rd makes the held value dead
                    waw_kill_s = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    if ((int'(wait_cnt_q) + 1) >= (MAX_WAIT - 1)) begin
                        state_d = ST_FORCE;
                    end else begin
                        state_d = ST_PEND;
                    end
                end
            end
            ST_FORCE: begin
                // Pipe input is ignored this cycle; pipe_stall_o makes it re-present
                rf_s    = '{wr_en: 1'b1, wr_addr: hold_addr_q, wr_data: hold_data_q};
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, hold register and wait counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hold_addr_q <= 5'd0;
            hold_data_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    // Handshake/stall outputs decode the state only: no comb path from inputs
    assign div_ready_o    = (state_q == ST_IDLE);
    assign pipe_stall_o   = (state_q == ST_FORCE);
    assign pend_valid_o   = (state_q != ST_IDLE);
    assign pend_rd_addr_o = pend_valid_o ? hold_addr_q : 5'd0;

    assign rf_wr_en_o     = rf_s.wr_en;
    assign rf_wr_addr_o   = rf_s.wr_addr;
    assign rf_wr_data_o   = rf_s.wr_data;

`ifdef WRB_ARB_PERF_EN
    wrb_arb_perf #(
        .PERF_W(PERF_W)
    ) u_perf (
        .clk            (clk),
        .rst            (rst),
        .force_i        (state_q == ST_FORCE),
        .waw_kill_i     (waw_kill_s),
        .force_cnt_o    (perf_force_cnt_o),
        .waw_kill_cnt_o (perf_waw_kill_cnt_o)
    );
`else
    logic perf_unused_s;
    assign perf_unused_s = waw_kill_s;
`endif

endmodule
